// File: rtl/commit_pkg.sv
// Shared types and constants for the commit-queue slot allocator.
package commit_pkg;

  localparam int NCOMMIT    = 32;
  localparam int LNCOMMIT   = 5;
  localparam int NDEC       = 4;
  localparam int NRETIRE    = 8;
  localparam int REC_CYCLES = 2;

  typedef logic [LNCOMMIT-1:0] commit_idx_t;
  typedef logic [LNCOMMIT:0]   commit_cnt_t;

  typedef enum logic [1:0] {RUN, REC1, REC2} alloc_state_t;

endpackage

// File: rtl/commit_alloc_if.sv
// Rename/commit side bus of the commit-queue slot allocator.
interface commit_alloc_if;
  import commit_pkg::*;

  logic [3:0]           alloc_count;
  logic [3:0]           retire_count;
  logic                 flush;
  commit_idx_t          flush_addr;
  commit_idx_t          next_start;
  commit_idx_t          current_end;
  commit_cnt_t          current_available;
  logic [NCOMMIT-1:0]   live_mask;
  logic                 recovering;
  logic                 overflow_err;

  modport master (
    output alloc_count, retire_count, flush, flush_addr,
    input  next_start, current_end, current_available, live_mask,
           recovering, overflow_err
  );

  modport slave (
    input  alloc_count, retire_count, flush, flush_addr,
    output next_start, current_end, current_available, live_mask,
           recovering, overflow_err
  );

endinterface

// File: rtl/commit_range_mask.sv
// Wrapped range mask: bit i set iff i lies in [start, start+len) mod NCOMMIT.
module commit_range_mask
  import commit_pkg::*;
(
  input  commit_idx_t        start,
  input  commit_cnt_t        len,
  output logic [NCOMMIT-1:0] mask
);

  commit_idx_t off;

  always_comb begin
    off  = '0;
    mask = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      off     = commit_idx_t'(i) - start;
      mask[i] = ({1'b0, off} < len);
    end
  end

endmodule

// File: rtl/commit_alloc.sv
// Commit-queue slot allocator: head/tail/count/live-mask tracking with flush recovery.
// Optional statistics outputs (hwm, full_cycles) under COMMIT_ALLOC_STATS_EN.
module commit_alloc
  import commit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  commit_alloc_if.slave bus
`ifdef COMMIT_ALLOC_STATS_EN
  ,
  output commit_cnt_t   hwm,
  output logic [31:0]   full_cycles
`endif
);

  commit_idx_t        head, tail, head_n, tail_n, clr_start;
  commit_cnt_t        count, count_n, avail, r_eff, a_eff, clr_len;
  logic [NCOMMIT-1:0] mask, mask_n, set_mask, clr_mask;
  alloc_state_t       state;
  logic               recovering, overflow_err;
  logic               retire_ok, alloc_req, alloc_ok, err_n;

  // Allocation may reuse slots freed by same-cycle retirement.
  always_comb begin
    retire_ok = (commit_cnt_t'(bus.retire_count) <= count);
    r_eff     = retire_ok ? commit_cnt_t'(bus.retire_count) : '0;
    alloc_req = !bus.flush && (state == RUN);
    alloc_ok  = (commit_cnt_t'(bus.alloc_count) <= (commit_cnt_t'(NCOMMIT) - count + r_eff));
    a_eff     = (alloc_req && alloc_ok) ? commit_cnt_t'(bus.alloc_count) : '0;
    head_n    = head + commit_idx_t'(r_eff);
    if (bus.flush) begin
      tail_n    = bus.flush_addr + commit_idx_t'(1);
      count_n   = commit_cnt_t'(commit_idx_t'(bus.flush_addr - head)) + commit_cnt_t'(1) - r_eff;
      clr_start = head_n;
      clr_len   = count_n;
    end else begin
      tail_n    = tail + commit_idx_t'(a_eff);
      count_n   = count + a_eff - r_eff;
      clr_start = head;
      clr_len   = r_eff;
    end
    // On flush the clear instance produces the keep window instead.
    mask_n = bus.flush ? (mask & clr_mask) : ((mask & ~clr_mask) | set_mask);
    err_n  = overflow_err | !retire_ok | (alloc_req && !alloc_ok);
  end

  commit_range_mask u_set_mask (
    .start (tail),
    .len   (a_eff),
    .mask  (set_mask)
  );

  commit_range_mask u_clr_mask (
    .start (clr_start),
    .len   (clr_len),
    .mask  (clr_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      avail        <= commit_cnt_t'(NCOMMIT);
      mask         <= '0;
      state        <= RUN;
      recovering   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      head         <= head_n;
      tail         <= tail_n;
      count        <= count_n;
      avail        <= commit_cnt_t'(NCOMMIT) - count_n;
      mask         <= mask_n;
      overflow_err <= err_n;
      if (bus.flush) begin
        state      <= REC1;
        recovering <= 1'b1;
      end else begin
        case (state)
          RUN:  begin state <= RUN;  recovering <= 1'b0; end
          REC1: begin state <= REC2; recovering <= 1'b1; end
          REC2: begin state <= RUN;  recovering <= 1'b0; end
          default: begin state <= RUN; recovering <= 1'b0; end
        endcase
      end
    end
  end

  assign bus.next_start        = tail;
  assign bus.current_end       = head;
  assign bus.current_available = avail;
  assign bus.live_mask         = mask;
  assign bus.recovering        = recovering;
  assign bus.overflow_err      = overflow_err;

`ifdef COMMIT_ALLOC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm         <= '0;
      full_cycles <= '0;
    end else begin
      if (count > hwm) hwm <= count;
      if ((count == commit_cnt_t'(NCOMMIT)) && (full_cycles != 32'hFFFF_FFFF))
        full_cycles <= full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_alloc.sv
// Randomized and directed bench for commit_alloc against a slot-array reference model.
module tb_commit_alloc;
  import commit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  commit_alloc_if bus ();

`ifdef COMMIT_ALLOC_STATS_EN
  commit_cnt_t hwm;
  logic [31:0] full_cycles;
`endif

  commit_alloc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef COMMIT_ALLOC_STATS_EN
    ,
    .hwm         (hwm),
    .full_cycles (full_cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: slot occupancy array plus plain integer pointers.
  int     m_head, m_tail, m_cnt, m_rec, m_hwm;
  longint m_fc;
  bit     m_err;
  bit     m_live [NCOMMIT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCOMMIT; i++) v[i] = m_live[i];
    return v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit rst, input int ac, input int rc, input bit fl, input int fa);
    int r, a, old;
    if (rst) begin
      m_head = 0; m_tail = 0; m_cnt = 0; m_rec = 0; m_err = 0; m_hwm = 0; m_fc = 0;
      for (int i = 0; i < NCOMMIT; i++) m_live[i] = 0;
      return;
    end
    if (m_cnt > m_hwm) m_hwm = m_cnt;
    if (m_cnt == NCOMMIT && m_fc != 64'hFFFF_FFFF) m_fc++;
    r = rc;
    if (rc > m_cnt) begin m_err = 1; r = 0; end
    if (fl) begin
      old    = m_head;
      m_head = (m_head + r) % NCOMMIT;
      m_tail = (fa + 1) % NCOMMIT;
      m_cnt  = ((fa - old + NCOMMIT) % NCOMMIT) + 1 - r;
      for (int i = 0; i < NCOMMIT; i++)
        m_live[i] = m_live[i] && (((i - m_head + NCOMMIT) % NCOMMIT) < m_cnt);
      m_rec = REC_CYCLES;
    end else begin
      for (int k = 0; k < r; k++) m_live[(m_head + k) % NCOMMIT] = 0;
      m_head = (m_head + r) % NCOMMIT;
      m_cnt  = m_cnt - r;
      if (m_rec > 0) m_rec--;
      else begin
        a = ac;
        if (a > NCOMMIT - m_cnt) begin m_err = 1; a = 0; end
        for (int k = 0; k < a; k++) m_live[(m_tail + k) % NCOMMIT] = 1;
        m_tail = (m_tail + a) % NCOMMIT;
        m_cnt  = m_cnt + a;
      end
    end
  endtask

  task automatic check_all();
    chk("next_start", bus.next_start, m_tail);
    chk("current_end", bus.current_end, m_head);
    chk("current_available", bus.current_available, NCOMMIT - m_cnt);
    chk("live_mask", bus.live_mask, m_mask());
    chk("recovering", bus.recovering, (m_rec > 0));
    chk("overflow_err", bus.overflow_err, m_err);
`ifdef COMMIT_ALLOC_STATS_EN
    chk("hwm", hwm, m_hwm);
    chk("full_cycles", full_cycles, m_fc);
`endif
  endtask

  task automatic cycle(input int ac, input int rc, input bit fl, input int fa, input bit rst = 1'b0);
    @(negedge clk);
    reset            = rst;
    bus.alloc_count  = 4'(ac);
    bus.retire_count = 4'(rc);
    bus.flush        = fl;
    bus.flush_addr   = commit_idx_t'(fa);
    @(posedge clk);
    model_step(rst, ac, rc, fl, fa);
    #1;
    check_all();
  endtask

  initial begin
    int ac, rc, fa, k;
    bit fl;
    reset = 1'b1;
    bus.alloc_count = '0; bus.retire_count = '0; bus.flush = 1'b0; bus.flush_addr = '0;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("rst_next_start", bus.next_start, 0);
    chk("rst_avail", bus.current_available, 32);
    chk("rst_err", bus.overflow_err, 0);

    // Fill from empty.
    for (int i = 1; i <= 4; i++) begin
      cycle(8, 0, 0, 0);
      chk("fill_next_start", bus.next_start, (8 * i) % 32);
      chk("fill_avail", bus.current_available, 32 - 8 * i);
    end
    chk("fill_mask", bus.live_mask, 32'hFFFF_FFFF);

    // Retire and re-allocate while full.
    cycle(3, 3, 0, 0);
    chk("swap_head", bus.current_end, 3);
    chk("swap_tail", bus.next_start, 3);
    chk("swap_avail", bus.current_available, 0);
    chk("swap_mask", bus.live_mask, 32'hFFFF_FFFF);
    chk("swap_err", bus.overflow_err, 0);

    // Reach head=28, tail=4, then flush.
    cycle(0, 8, 0, 0); cycle(0, 8, 0, 0); cycle(0, 8, 0, 0); cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    chk("pre_flush_head", bus.current_end, 28);
    chk("pre_flush_tail", bus.next_start, 4);
    chk("pre_flush_avail", bus.current_available, 24);
    cycle(5, 1, 1, 30);
    chk("flush_head", bus.current_end, 29);
    chk("flush_tail", bus.next_start, 31);
    chk("flush_avail", bus.current_available, 30);
    chk("flush_mask", bus.live_mask, 32'h6000_0000);
    chk("flush_rec", bus.recovering, 1);
    cycle(5, 0, 0, 0);
    chk("rec1_rec", bus.recovering, 1);
    cycle(5, 0, 0, 0);
    chk("rec2_rec", bus.recovering, 0);
    chk("rec_tail", bus.next_start, 31);

    // Flush again, then flush during REC2.
    cycle(5, 0, 1, 30);
    cycle(5, 0, 0, 0);
    cycle(5, 0, 1, 30);
    chk("reflush_rec", bus.recovering, 1);
    cycle(5, 0, 0, 0);
    chk("reflush_rec_b", bus.recovering, 1);
    chk("reflush_tail", bus.next_start, 31);
    cycle(5, 0, 0, 0);
    chk("reflush_done", bus.recovering, 0);
    chk("reflush_tail_b", bus.next_start, 31);
    cycle(2, 0, 0, 0);
    chk("resume_tail", bus.next_start, 1);
    chk("resume_avail", bus.current_available, 28);

    // Overflow at count=30.
    cycle(8, 0, 0, 0); cycle(8, 0, 0, 0); cycle(8, 0, 0, 0); cycle(2, 0, 0, 0);
    cycle(4, 0, 0, 0);
    chk("ovf_err", bus.overflow_err, 1);
    chk("ovf_tail", bus.next_start, 27);
    chk("ovf_avail", bus.current_available, 2);
    cycle(0, 0, 0, 0);
    chk("ovf_sticky", bus.overflow_err, 1);
    cycle(0, 0, 0, 0, 1);
    chk("ovf_reset", bus.overflow_err, 0);

`ifdef COMMIT_ALLOC_STATS_EN
    for (int i = 0; i < 4; i++) cycle(8, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 8, 0, 0);
    chk("stats_hwm", hwm, 32);
    chk("stats_full_cycles", full_cycles, 5);
`endif

    // Randomized traffic, mostly legal.
    for (int n = 0; n < 3000; n++) begin
      fl = 0; fa = 0;
      if ($urandom_range(0, 199) == 0) begin
        cycle(0, 0, 0, 0, 1);
        continue;
      end
      if (m_cnt > 0 && $urandom_range(0, 19) == 0) begin
        fl = 1;
        k  = $urandom_range(1, m_cnt);
        fa = (m_head + k - 1) % NCOMMIT;
        rc = $urandom_range(0, imin(k, 8));
        ac = $urandom_range(0, 15);
      end else if ($urandom_range(0, 29) == 0) begin
        ac = $urandom_range(0, 15);
        rc = $urandom_range(0, 15);
      end else begin
        rc = $urandom_range(0, imin(m_cnt, 8));
        ac = $urandom_range(0, imin(8, NCOMMIT - m_cnt + rc));
      end
      cycle(ac, rc, fl, fa);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
